dbus_sram_responder: RTL

DBUS_SRAM_RESPONDER -- requirements
Module: dbus_sram_responder

---
 rtl/dbus_sram_responder.sv | 81 ++++++++
 1 files changed

// File: rtl/dbus_sram_responder.sv
// Single-ported word SRAM behind a request/ready data bus with a fixed-latency,
// stallable load-return pipeline. Stores write in the acceptance cycle; loads return PIPE_DEPTH-1 cycles later.
module dbus_sram_responder #(
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned WORDS      = 4096,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dbus_request,
  output logic        dbus_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_paddr,
  input  logic [3:0]  req_byteenable,
  input  logic [31:0] req_wrdata,
  input  logic        stall_inject,
  output logic        res_stall,
  output logic [31:0] res_rddata,
  output logic        res_valid,
  output logic        res_err
);

  localparam int unsigned NST  = PIPE_DEPTH - 1;
  localparam int unsigned AW   = $clog2(WORDS);
  localparam logic [32:0] SPAN = 33'(WORDS) << 2;

  logic [31:0]           mem [WORDS];
  logic [31:0]           off;
  logic                  in_range;
  logic [AW-1:0]         idx;
  logic                  accept;
  logic                  do_store;
  logic                  do_load;
  logic [NST-1:0]        st_valid;
  logic [NST-1:0]        st_err;
  logic [NST-1:0][31:0]  st_data;

  assign res_stall  = stall_inject;
  assign dbus_ready = rst_n & ~stall_inject;

  // Offsets below BASE_ADDR wrap to large values and so fall out of range.
  assign off      = req_paddr - BASE_ADDR;
  assign in_range = {1'b0, off} < SPAN;
  assign idx      = off[AW+1:2];

  // Acceptance implies no stall, so a load always enters on an advancing edge.
  assign accept   = dbus_request & dbus_ready;
  assign do_store = accept & req_write;
  assign do_load  = accept & req_read & ~req_write;

  always_ff @(posedge clk) begin
    if (do_store && in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (req_byteenable[b]) mem[idx][8*b +: 8] <= req_wrdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid <= '0;
      st_err   <= '0;
      st_data  <= '0;
    end else if (!stall_inject) begin
      st_valid[0] <= do_load;
      st_err[0]   <= do_load & ~in_range;
      st_data[0]  <= (do_load && in_range) ? mem[idx] : '0;
      for (int unsigned s = 1; s < NST; s++) begin
        st_valid[s] <= st_valid[s-1];
        st_err[s]   <= st_err[s-1];
        st_data[s]  <= st_data[s-1];
      end
    end
  end

  assign res_valid  = st_valid[NST-1];
  assign res_err    = st_err[NST-1];
  assign res_rddata = st_data[NST-1];

endmodule
